// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU pixel-path widths, constants and sprite-pixel bundle
package ppu_pkg;

   localparam int PAL_ADDR_W = 5;
   localparam int COLOR_W    = 6;

   localparam logic [PAL_ADDR_W-1:0] BACKDROP_ADDR = 5'h00;

   typedef struct packed {
      logic [1:0] pat;
      logic [1:0] pal;
      logic       behind;
      logic       is_zero;
   } spr_pix_t;

   localparam int SPR_PIX_W = $bits(spr_pix_t);

   // Grayscale keeps only the luma row of the colour index.
   function automatic logic [COLOR_W-1:0] apply_gray(input logic gray,
                                                     input logic [COLOR_W-1:0] c);
      return gray ? {c[5:4], 4'b0000} : c;
   endfunction

endpackage

// File: rtl/ppu_prio_resolve.sv
// rtl/ppu_prio_resolve.sv - combinational bg/sprite opacity, priority and palette address select
module ppu_prio_resolve
   import ppu_pkg::*;
#(
   parameter int X_W       = 8,
   parameter int LEFT_CLIP = 8
) (
   input  logic [X_W-1:0]        dot_x,
   input  logic                  show_bg,
   input  logic                  show_spr,
   input  logic                  show_bg_left,
   input  logic                  show_spr_left,
   input  logic [1:0]            bg_pat,
   input  logic [1:0]            bg_pal,
   input  logic [SPR_PIX_W-1:0]  spr_pix,
   input  logic [13:0]           vaddr,
   output logic [PAL_ADDR_W-1:0] addr,
   output logic                  hit_cand
);

   spr_pix_t spr;
   logic     left;
   logic     bg_op;
   logic     sp_op;
   logic     render_off;
   logic     unused_vaddr;

   assign spr          = spr_pix_t'(spr_pix);
   assign left         = (dot_x < X_W'(LEFT_CLIP));
   assign bg_op        = show_bg  & (~left | show_bg_left)  & (bg_pat  != 2'b00);
   assign sp_op        = show_spr & (~left | show_spr_left) & (spr.pat != 2'b00);
   assign render_off   = ~show_bg & ~show_spr;
   assign unused_vaddr = ^vaddr[7:5];

   // Hit ignores sprite priority; the last dot of the line never hits.
   assign hit_cand = bg_op & sp_op & spr.is_zero & (dot_x != X_W'(255));

   always_comb begin
      addr = BACKDROP_ADDR;
      if (render_off) begin
         // With rendering off the backdrop follows vaddr when it points into palette space.
         if (vaddr[13:8] == 6'h3F)
            addr = vaddr[4:0];
      end else if (sp_op && (!bg_op || !spr.behind)) begin
         addr = {1'b1, spr.pal, spr.pat};
      end else if (bg_op) begin
         addr = {1'b0, bg_pal, bg_pat};
      end
   end

endmodule

// File: rtl/ppu_pixel_mux.sv
// rtl/ppu_pixel_mux.sv - two-stage PPU pixel pipeline; PPU_PIXEL_MUX_EMPHASIS_EN builds the emphasis delay line
module ppu_pixel_mux
   import ppu_pkg::*;
#(
   parameter int X_W       = 8,
   parameter int LEFT_CLIP = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  pix_en,
   input  logic [X_W-1:0]        dot_x,
   input  logic                  clear_flags,
   input  logic                  show_bg,
   input  logic                  show_spr,
   input  logic                  show_bg_left,
   input  logic                  show_spr_left,
   input  logic                  grayscale,
   input  logic [2:0]            emphasis,
   input  logic [1:0]            bg_pat,
   input  logic [1:0]            bg_pal,
   input  logic [1:0]            spr_pat,
   input  logic [1:0]            spr_pal,
   input  logic                  spr_behind,
   input  logic                  spr_is_zero,
   input  logic [13:0]           vaddr,
   output logic [PAL_ADDR_W-1:0] pal_addr,
   input  logic [COLOR_W-1:0]    pal_data,
   output logic                  pix_valid,
   output logic [COLOR_W-1:0]    pix_color,
   output logic [2:0]            pix_emph,
   output logic                  spr0_hit
);

   spr_pix_t              spr;
   logic [PAL_ADDR_W-1:0] addr_next;
   logic                  hit_cand;
   logic                  en_q1;
   logic                  gray_q1;

   assign spr = '{pat: spr_pat, pal: spr_pal, behind: spr_behind, is_zero: spr_is_zero};

   ppu_prio_resolve #(
      .X_W       (X_W),
      .LEFT_CLIP (LEFT_CLIP)
   ) u_prio (
      .dot_x         (dot_x),
      .show_bg       (show_bg),
      .show_spr      (show_spr),
      .show_bg_left  (show_bg_left),
      .show_spr_left (show_spr_left),
      .bg_pat        (bg_pat),
      .bg_pal        (bg_pal),
      .spr_pix       (spr),
      .vaddr         (vaddr),
      .addr          (addr_next),
      .hit_cand      (hit_cand)
   );

   // Stage 1: address and per-dot controls; stage 2: palette data to colour.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pal_addr  <= BACKDROP_ADDR;
         en_q1     <= 1'b0;
         gray_q1   <= 1'b0;
         pix_valid <= 1'b0;
         pix_color <= '0;
      end else begin
         en_q1     <= pix_en;
         pix_valid <= en_q1;
         if (pix_en) begin
            pal_addr <= addr_next;
            gray_q1  <= grayscale;
         end
         if (en_q1)
            pix_color <= apply_gray(gray_q1, pal_data);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         spr0_hit <= 1'b0;
      else if (clear_flags)
         spr0_hit <= 1'b0;
      else if (pix_en && hit_cand)
         spr0_hit <= 1'b1;
   end

`ifdef PPU_PIXEL_MUX_EMPHASIS_EN
   logic [2:0] emph_q1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         emph_q1  <= 3'b000;
         pix_emph <= 3'b000;
      end else begin
         if (pix_en)
            emph_q1 <= emphasis;
         if (en_q1)
            pix_emph <= emph_q1;
      end
   end
`else
   logic unused_emphasis;

   assign unused_emphasis = ^emphasis;
   assign pix_emph        = 3'b000;
`endif

endmodule

// File: tb/tb_ppu_pixel_mux.sv
// tb/tb_ppu_pixel_mux.sv - directed and randomized checks of ppu_pixel_mux against a rule-level model
module tb_ppu_pixel_mux;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       pix_en;
   logic [7:0] dot_x;
   logic       clear_flags;
   logic       show_bg, show_spr, show_bg_left, show_spr_left;
   logic       grayscale;
   logic [2:0] emphasis;
   logic [1:0] bg_pat, bg_pal, spr_pat, spr_pal;
   logic       spr_behind, spr_is_zero;
   logic [13:0] vaddr;
   logic [4:0] pal_addr;
   logic [5:0] pal_data;
   logic       pix_valid;
   logic [5:0] pix_color;
   logic [2:0] pix_emph;
   logic       spr0_hit;

   logic [5:0] pal_ram [32];
   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic       valid;
      logic [5:0] color;
      logic [2:0] emph;
   } exp_t;

   always #5 clock = ~clock;

   assign pal_data = pal_ram[pal_addr];

   ppu_pixel_mux dut (
      .clock(clock), .reset_n(reset_n), .pix_en(pix_en), .dot_x(dot_x),
      .clear_flags(clear_flags), .show_bg(show_bg), .show_spr(show_spr),
      .show_bg_left(show_bg_left), .show_spr_left(show_spr_left),
      .grayscale(grayscale), .emphasis(emphasis), .bg_pat(bg_pat), .bg_pal(bg_pal),
      .spr_pat(spr_pat), .spr_pal(spr_pal), .spr_behind(spr_behind),
      .spr_is_zero(spr_is_zero), .vaddr(vaddr), .pal_addr(pal_addr),
      .pal_data(pal_data), .pix_valid(pix_valid), .pix_color(pix_color),
      .pix_emph(pix_emph), .spr0_hit(spr0_hit)
   );

   function automatic logic ref_bg_op();
      return show_bg && (dot_x >= 8 || show_bg_left) && bg_pat != 0;
   endfunction

   function automatic logic ref_sp_op();
      return show_spr && (dot_x >= 8 || show_spr_left) && spr_pat != 0;
   endfunction

   function automatic logic [4:0] ref_addr();
      if (!show_bg && !show_spr)
         return (vaddr[13:8] == 6'h3F) ? vaddr[4:0] : 5'h00;
      if (!ref_bg_op() && !ref_sp_op())
         return 5'h00;
      if (ref_sp_op() && (!ref_bg_op() || !spr_behind))
         return 5'h10 + 5'(spr_pal * 4) + 5'(spr_pat);
      return 5'(bg_pal * 4) + 5'(bg_pat);
   endfunction

   function automatic logic [2:0] ref_emph(input logic [2:0] e);
`ifdef PPU_PIXEL_MUX_EMPHASIS_EN
      return e;
`else
      return (e == 3'b111) ? 3'b000 : 3'b000;
`endif
   endfunction

   task automatic set_defaults();
      pix_en = 0; dot_x = 0; clear_flags = 0;
      show_bg = 0; show_spr = 0; show_bg_left = 0; show_spr_left = 0;
      grayscale = 0; emphasis = 0; bg_pat = 0; bg_pal = 0;
      spr_pat = 0; spr_pal = 0; spr_behind = 0; spr_is_zero = 0; vaddr = 0;
   endtask

   task automatic do_reset();
      set_defaults();
      @(negedge clock);
      reset_n = 0;
      @(negedge clock);
      reset_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 32; i++) pal_ram[i] = 6'(i + 1);
      show_bg = 1; show_bg_left = 1; bg_pat = 1; bg_pal = 2; dot_x = 40;
      emphasis = 3'b011; pix_en = 1; spr_pat = 1; show_spr = 1; spr_is_zero = 1;
      repeat (3) @(posedge clock);
      #1;
      tests_run++;
      if (pix_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_pre_valid: got %b expected 1", pix_valid);
      end
      #2 reset_n = 0;
      #1;
      tests_run++;
      if ({pal_addr, pix_valid, pix_color, pix_emph, spr0_hit} !== 16'h0) begin
         tests_failed++;
         $display("FAIL reset_async: addr=%h valid=%b color=%h emph=%b hit=%b expected all 0",
                  pal_addr, pix_valid, pix_color, pix_emph, spr0_hit);
      end
      @(negedge clock);
      reset_n = 1;
      @(posedge clock); #1;
      tests_run++;
      if (pix_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valid_c1: got %b expected 0", pix_valid);
      end
      @(posedge clock); #1;
      tests_run++;
      if (pix_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_valid_c2: got %b expected 1", pix_valid);
      end
   endtask

   task automatic test_priority();
      do_reset();
      show_bg = 1; show_spr = 1; show_bg_left = 1; show_spr_left = 1; dot_x = 100;
      bg_pat = 2; bg_pal = 1; spr_pat = 3; spr_pal = 2; spr_behind = 0;
      pal_ram[5'h1B] = 6'h2A; pix_en = 1;
      @(posedge clock); #1;
      tests_run++;
      if (pal_addr !== 5'h1B) begin
         tests_failed++;
         $display("FAIL prio_front_addr: got %h expected 1b", pal_addr);
      end
      pix_en = 0;
      @(posedge clock); #1;
      tests_run++;
      if (pix_valid !== 1'b1 || pix_color !== 6'h2A) begin
         tests_failed++;
         $display("FAIL prio_color: valid=%b color=%h expected 1/2a", pix_valid, pix_color);
      end
      spr_behind = 1; pix_en = 1;
      @(posedge clock); #1;
      tests_run++;
      if (pal_addr !== 5'h06) begin
         tests_failed++;
         $display("FAIL prio_behind_addr: got %h expected 06", pal_addr);
      end
   endtask

   task automatic test_transparency();
      do_reset();
      show_bg = 1; show_spr = 1; show_bg_left = 1; show_spr_left = 1; dot_x = 60;
      bg_pat = 3; bg_pal = 3; pix_en = 1;
      @(posedge clock); #1;
      bg_pat = 0; spr_pat = 0;
      @(posedge clock); #1;
      tests_run++;
      if (pal_addr !== 5'h00) begin
         tests_failed++;
         $display("FAIL transp_backdrop: got %h expected 00", pal_addr);
      end
      spr_pat = 1; spr_pal = 3;
      @(posedge clock); #1;
      tests_run++;
      if (pal_addr !== 5'h1D) begin
         tests_failed++;
         $display("FAIL transp_spr_only: got %h expected 1d", pal_addr);
      end
   endtask

   task automatic test_left_clip();
      do_reset();
      show_bg = 1; show_spr = 1; show_bg_left = 0; show_spr_left = 1;
      dot_x = 5; bg_pat = 3; bg_pal = 2; spr_pat = 1; spr_pal = 0;
      spr_behind = 1; spr_is_zero = 1; pix_en = 1;
      @(posedge clock); #1;
      tests_run++;
      if (pal_addr !== 5'h11 || spr0_hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL clip_left: addr=%h hit=%b expected 11/0", pal_addr, spr0_hit);
      end
      dot_x = 8;
      @(posedge clock); #1;
      tests_run++;
      if (pal_addr !== 5'h0B || spr0_hit !== 1'b1) begin
         tests_failed++;
         $display("FAIL clip_x8_hit: addr=%h hit=%b expected 0b/1", pal_addr, spr0_hit);
      end
      pix_en = 0; clear_flags = 1;
      @(posedge clock); #1;
      clear_flags = 0; dot_x = 255; pix_en = 1;
      repeat (2) @(posedge clock);
      #1;
      tests_run++;
      if (spr0_hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL clip_x255_nohit: got %b expected 0", spr0_hit);
      end
   endtask

   task automatic test_render_off();
      do_reset();
      vaddr = 14'h3F07; pix_en = 1;
      @(posedge clock); #1;
      tests_run++;
      if (pal_addr !== 5'h07) begin
         tests_failed++;
         $display("FAIL render_off_pal: got %h expected 07", pal_addr);
      end
      vaddr = 14'h2000;
      @(posedge clock); #1;
      tests_run++;
      if (pal_addr !== 5'h00) begin
         tests_failed++;
         $display("FAIL render_off_vram: got %h expected 00", pal_addr);
      end
   endtask

   task automatic test_gray_emph();
      do_reset();
      show_bg = 1; show_bg_left = 1; dot_x = 30; bg_pat = 1; bg_pal = 0;
      pal_ram[5'h01] = 6'h27; grayscale = 1; emphasis = 3'b101; pix_en = 1;
      @(posedge clock); #1;
      pix_en = 0; grayscale = 0; emphasis = 3'b010;
      @(posedge clock); #1;
      tests_run++;
      if (pix_valid !== 1'b1 || pix_color !== 6'h20) begin
         tests_failed++;
         $display("FAIL gray_color: valid=%b color=%h expected 1/20", pix_valid, pix_color);
      end
      tests_run++;
      if (pix_emph !== ref_emph(3'b101)) begin
         tests_failed++;
         $display("FAIL emph_align: got %b expected %b", pix_emph, ref_emph(3'b101));
      end
   endtask

   task automatic test_clear_wins();
      do_reset();
      show_bg = 1; show_spr = 1; dot_x = 50; bg_pat = 2; spr_pat = 2;
      spr_is_zero = 1; spr_behind = 1; pix_en = 1;
      @(posedge clock); #1;
      tests_run++;
      if (spr0_hit !== 1'b1) begin
         tests_failed++;
         $display("FAIL hit_set: got %b expected 1", spr0_hit);
      end
      clear_flags = 1;
      @(posedge clock); #1;
      tests_run++;
      if (spr0_hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL clear_wins: got %b expected 0", spr0_hit);
      end
   endtask

   task automatic test_random();
      exp_t       q[$];
      exp_t       e;
      logic [4:0] m_addr = 0;
      logic       m_hit = 0;
      logic [5:0] m_color = 0;
      logic [2:0] m_emph = 0;
      logic [4:0] a;
      do_reset();
      for (int i = 0; i < 32; i++) pal_ram[i] = 6'($urandom);
      for (int n = 0; n < 400; n++) begin
         pix_en        = ($urandom_range(0, 4) != 0);
         dot_x         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) :
                         ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom);
         clear_flags   = ($urandom_range(0, 15) == 0);
         show_bg       = ($urandom_range(0, 3) != 0);
         show_spr      = ($urandom_range(0, 3) != 0);
         show_bg_left  = 1'($urandom);
         show_spr_left = 1'($urandom);
         grayscale     = ($urandom_range(0, 3) == 0);
         emphasis      = 3'($urandom);
         bg_pat        = 2'($urandom); bg_pal  = 2'($urandom);
         spr_pat       = 2'($urandom); spr_pal = 2'($urandom);
         spr_behind    = 1'($urandom);
         spr_is_zero   = ($urandom_range(0, 2) == 0);
         vaddr         = ($urandom_range(0, 1) == 0) ? {6'h3F, 8'($urandom)} : 14'($urandom);
         a = ref_addr();
         if (pix_en) begin
            m_addr  = a;
            m_color = grayscale ? (pal_ram[a] & 6'h30) : pal_ram[a];
            m_emph  = ref_emph(emphasis);
            q.push_back('{1'b1, m_color, m_emph});
         end else begin
            q.push_back('{1'b0, m_color, m_emph});
         end
         if (clear_flags)
            m_hit = 0;
         else if (pix_en && ref_bg_op() && ref_sp_op() && spr_is_zero && dot_x != 255)
            m_hit = 1;
         @(posedge clock); #1;
         tests_run++;
         if (pal_addr !== m_addr || spr0_hit !== m_hit) begin
            tests_failed++;
            $display("FAIL rand_stage1[%0d]: addr=%h hit=%b expected %h/%b",
                     n, pal_addr, spr0_hit, m_addr, m_hit);
         end
         if (q.size() == 2) begin
            e = q.pop_front();
            tests_run++;
            if (pix_valid !== e.valid || pix_color !== e.color || pix_emph !== e.emph) begin
               tests_failed++;
               $display("FAIL rand_out[%0d]: valid=%b color=%h emph=%b expected %b/%h/%b",
                        n, pix_valid, pix_color, pix_emph, e.valid, e.color, e.emph);
            end
         end
      end
   endtask

   initial begin
      reset_n = 1;
      set_defaults();
      for (int i = 0; i < 32; i++) pal_ram[i] = 6'h00;
      test_reset();
      test_priority();
      test_transparency();
      test_left_clip();
      test_render_off();
      test_gray_emph();
      test_clear_wins();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ppu_pixel_mux.md
Name: ppu_pixel_mux

Overview:
- Final PPU pixel stage, directly downstream of the background/sprite shifters and directly upstream of the palette RAM read port.
- Each pixel clock it resolves background vs sprite priority and forms the 5-bit palette address driven to the palette RAM read port.
- It registers the returned 6-bit colour, applies grayscale and emphasis, and presents one colour per dot to the video encoder.
- Also owns the sticky sprite-0-hit flag.

Parameters:
- X_W, 8, width of dot x-coordinate (0..255 visible).
- LEFT_CLIP, 8, number of leftmost pixels affected by the left-column masks.

Ports:
- clock  in  1  PPU dot clock
- reset_n  in  1  asynchronous active-low reset
- pix_en  in  1  one visible dot this cycle
- dot_x  in  X_W  x of dot presented this cycle
- clear_flags  in  1  pre-render-line clear of sprite-0 hit
- show_bg  in  1  PPUMASK bit 3
- show_spr  in  1  PPUMASK bit 4
- show_bg_left  in  1  PPUMASK bit 1
- show_spr_left  in  1  PPUMASK bit 2
- grayscale  in  1  PPUMASK bit 0
- emphasis  in  3  PPUMASK bits 7:5
- bg_pat  in  2  background pattern bits
- bg_pal  in  2  background attribute/palette
- spr_pat  in  2  front sprite pattern bits
- spr_pal  in  2  front sprite palette
- spr_behind  in  1  sprite priority bit (1 = behind background)
- spr_is_zero  in  1  front sprite is OAM entry 0
- vaddr  in  14  current VRAM address, for the rendering-off backdrop
- pal_addr  out  5  palette RAM read address
- pal_data  in  6  palette RAM read data (combinational with pal_addr)
- pix_valid  out  1  colour output valid
- pix_color  out  6  final colour index
- pix_emph  out  3  emphasis bits aligned with pix_color
- spr0_hit  out  1  sticky sprite-0 hit

Behaviour:
- Reset (reset_n low, asynchronous): pal_addr=0, pix_valid=0, pix_color=0, pix_emph=0, spr0_hit=0, all pipeline registers zeroed.
- Stage 1, cycle N, when pix_en=1:
  - left = (dot_x < LEFT_CLIP).
  - bg_op = show_bg & (~left | show_bg_left) & (bg_pat != 0).
  - sp_op = show_spr & (~left | show_spr_left) & (spr_pat != 0).
  - Address select:
    - Neither opaque: backdrop, address 5'h00.
    - Sprite opaque only, or both opaque with spr_behind=0: {1'b1, spr_pal, spr_pat}.
    - Otherwise: {1'b0, bg_pal, bg_pat}.
  - Rendering off (show_bg=0 and show_spr=0):
    - If vaddr[13:8]=6'h3F, address is vaddr[4:0].
    - Else address is 5'h00.
  - pal_addr is registered at the end of cycle N.
- Stage 2, cycle N+1: pal_data is sampled; pix_color = grayscale_q ? {pal_data[5:4], 4'b0} : pal_data. grayscale and emphasis are captured in stage 1 and delayed to match.
- pix_valid equals pix_en delayed by 2 cycles. Total latency is 2 clocks from pix_en to pix_valid.
- When pix_en=0, the pipeline still advances. pix_valid goes low and pix_color holds its last value.
- Sprite-0 hit:
  - Set in stage 1 when pix_en & bg_op & sp_op & spr_is_zero & (dot_x != 255). The mask terms already apply the left-column clipping.
  - Ignores spr_behind.
  - Sticky; cleared only by clear_flags or reset.
  - clear_flags and a set condition in the same cycle: clear wins.
- Mirroring of 5'h10/14/18/1C is done by the palette RAM. This block does not remap.
- Mid-frame changes to any mask input take effect on the next pix_en dot.

Optional Feature:
- Macro PPU_PIXEL_MUX_EMPHASIS_EN.
- Defined: pix_emph carries emphasis delayed 2 cycles, aligned with pix_color.
- Undefined: pix_emph is tied to 3'b000 and the emphasis pipeline flops are not built. The port still exists.

Decomposition:
- Shared ppu_pkg holds:
  - PAL_ADDR_W=5 and COLOR_W=6.
  - BACKDROP_ADDR=5'h00.
  - A typedef for the sprite-pixel bundle (pattern, palette, behind, is_zero).
- One sub-module, ppu_prio_resolve: the combinational priority/opacity logic that produces the address and the hit candidate. The top level holds the pipeline and the flag.

Test Plan:
- Reset: show_bg=1, drive pixels, assert reset_n low mid-stream -> all outputs 0 immediately; pix_valid stays 0 for 2 cycles after release.
- Priority: bg_pat=2, bg_pal=1, spr_pat=3, spr_pal=2, spr_behind=0 -> pal_addr=5'h1B; pal_data=6'h2A returns pix_color=6'h2A two cycles after pix_en. With spr_behind=1 -> pal_addr=5'h06.
- Transparency: bg_pat=0, spr_pat=0 -> pal_addr=5'h00. bg_pat=0, spr_pat=1, spr_pal=3 -> pal_addr=5'h1D.
- Left clip: dot_x=5, show_bg_left=0, spr_pat=1 opaque -> sprite address chosen and no spr0_hit. dot_x=8, both opaque, spr_is_zero=1 -> spr0_hit=1 next cycle; dot_x=255 case never sets it.
- Rendering off: show_bg=show_spr=0, vaddr=14'h3F07 -> pal_addr=5'h07. vaddr=14'h2000 -> pal_addr=5'h00.
- Grayscale/emphasis: grayscale=1, pal_data=6'h27 -> pix_color=6'h20. With PPU_PIXEL_MUX_EMPHASIS_EN defined, emphasis=3'b101 -> pix_emph=3'b101 aligned with that pixel; undefined -> 3'b000. clear_flags together with a hit condition -> spr0_hit=0.
